// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: owns PC, presents OPCODE, run/idle/halted FSM with retired-instruction counter.
// Latency: PC->OPCODE combinational; next-PC decision and state changes take effect at the next CLK edge.
// Backpressure: none; single-cycle issue, one instruction retires every cycle while RUNNING.
//
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   START, START_ADDR    level-sampled run request and its entry PC (accepted in IDLE/HALTED)
//   INSTR_IN             instruction word read from memory at PC
//   BRANCH, BRANCH_TAKEN, BRANCH_TARGET, HALT   next-PC controls, sampled only in RUN
//   PC, OPCODE           fetch address and instruction handed to the decoder
//   RUNNING, DONE        registered state decodes
//   INSTR_COUNT          saturating count of retired instructions since last START
module instr_fetch #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [PC_W-1:0]  START_ADDR,
    input  logic [8:0]       INSTR_IN,
    input  logic             BRANCH,
    input  logic             BRANCH_TAKEN,
    input  logic [PC_W-1:0]  BRANCH_TARGET,
    input  logic             HALT,
    output logic [PC_W-1:0]  PC,
    output logic [8:0]       OPCODE,
    output logic             RUNNING,
    output logic             DONE,
    output logic [CNT_W-1:0] INSTR_COUNT
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    // Decoder treats this word as an all-zero-control no-op.
    localparam logic [8:0] NOP_OPCODE = 9'h090;

    logic [1:0]       state;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] instr_count;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= ST_IDLE;
            pc          <= '0;
            instr_count <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (START) begin
                        state       <= ST_RUN;
                        pc          <= START_ADDR;
                        instr_count <= '0;
                    end
                end
                ST_RUN: begin
                    // The instruction at pc retires this cycle, including ht.
                    if (instr_count != {CNT_W{1'b1}}) begin
                        instr_count <= instr_count + CNT_W'(1);
                    end
                    // HALT wins over a branch: PC stays on the ht instruction.
                    if (HALT) begin
                        state <= ST_HALTED;
                    end else if (BRANCH && BRANCH_TAKEN) begin
                        pc <= BRANCH_TARGET;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status outputs come straight from the state register: no input-to-output path.
    assign RUNNING     = (state == ST_RUN);
    assign DONE        = (state == ST_HALTED);
    assign PC          = pc;
    assign INSTR_COUNT = instr_count;
    assign OPCODE      = RUNNING ? INSTR_IN : NOP_OPCODE;

endmodule
